// File: rtl/clk_gen_pkg.sv
// Shared constants and ratio helpers for the multi-channel clock generator.
// Helpers work on 32-bit values so any DIV_W up to 32 can reuse them.
package clk_gen_pkg;

    localparam int NUM_CH_DEF = 3;
    localparam int DIV_W_DEF  = 8;

    // Ratios below 2 cannot form a clock with both a high and a low phase.
    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d < 32'd2) ? 32'd2 : d;
    endfunction

    // Number of high cycles per period; odd ratios get the extra cycle high.
    function automatic logic [31:0] hi_cnt(input logic [31:0] d);
        return (d + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/clk_gen_multi_if.sv
// Ratio-write / sync control bundle and status returned by the generator.
// The master side programs ratios, the slave side is the generator.
interface clk_gen_multi_if #(
    parameter int NUM_CH = 3,
    parameter int DIV_W  = 8,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);

    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [DIV_W-1:0]  wr_div;
    logic              sync_req;
    logic [NUM_CH-1:0] pending;
    logic              running;

    modport master (
        output wr_en, wr_ch, wr_div, sync_req,
        input  pending, running
    );

    modport slave (
        input  wr_en, wr_ch, wr_div, sync_req,
        output pending, running
    );

endinterface

// File: rtl/clk_div_ch.sv
// One divided-clock channel: counter, active/next ratio and pending flag.
// Ratio changes land only on period boundaries, restarts or while stopped.
module clk_div_ch
    import clk_gen_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             sync,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
    input  logic [DIV_W-1:0] div_init,
    output logic             clk_o,
    output logic             pending_o
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_cur;
    logic [DIV_W-1:0] div_next;
    logic [DIV_W-1:0] wr_val;
    logic [DIV_W-1:0] init_val;
    logic             active;
    logic             last;
    logic             cnt_hi;

    assign wr_val   = DIV_W'(clamp_div(32'(wr_div)));
    assign init_val = DIV_W'(clamp_div(32'(div_init)));
    assign last     = (cnt == div_cur - DIV_W'(1));
    assign cnt_hi   = (32'(cnt) + 32'd1) < hi_cnt(32'(div_cur));

    // Counter, output and ratio update; a restart (first run cycle,
    // sync or wrap) always begins a fresh period with the newest ratio.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            clk_o     <= 1'b0;
            pending_o <= 1'b0;
            active    <= 1'b0;
            div_cur   <= init_val;
            div_next  <= init_val;
        end else begin
            active <= run;
            if (!run) begin
                cnt   <= '0;
                clk_o <= 1'b0;
                if (wr) begin
                    div_next  <= wr_val;
                    pending_o <= 1'b1;
                end else if (pending_o) begin
                    div_cur   <= div_next;
                    pending_o <= 1'b0;
                end
            end else if (sync || !active || last) begin
                cnt       <= '0;
                clk_o     <= 1'b1;
                pending_o <= 1'b0;
                if (wr) begin
                    div_cur  <= wr_val;
                    div_next <= wr_val;
                end else if (pending_o) begin
                    div_cur <= div_next;
                end
            end else begin
                cnt   <= cnt + DIV_W'(1);
                clk_o <= cnt_hi;
                if (wr) begin
                    div_next  <= wr_val;
                    pending_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/clk_gen_multi.sv
// N-channel programmable clock generator running from the PLL clock.
// Channels start once LOCKED is synchronised and can be re-phased by sync_req.
module clk_gen_multi
    import clk_gen_pkg::*;
#(
    parameter int                        NUM_CH   = NUM_CH_DEF,
    parameter int                        DIV_W    = DIV_W_DEF,
    parameter logic [NUM_CH*DIV_W-1:0]   DIV_INIT = 24'h0A_05_02,
    parameter int                        CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              locked_in,
    clk_gen_multi_if.slave    cfg,
    output logic [NUM_CH-1:0] clk_out
);

    logic              lock_meta;
    logic              lock_sync;
    logic              sync;
    logic [NUM_CH-1:0] pend;

    // Two-flop synchroniser for the asynchronous PLL lock indication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= locked_in;
            lock_sync <= lock_meta;
        end
    end

    assign sync        = cfg.sync_req & lock_sync;
    assign cfg.running = lock_sync;
    assign cfg.pending = pend;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic wr_sel;

        // Out-of-range channel numbers match no channel and are dropped.
        assign wr_sel = cfg.wr_en && (cfg.wr_ch == CH_W'(gi));

        clk_div_ch #(
            .DIV_W (DIV_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .run       (lock_sync),
            .sync      (sync),
            .wr        (wr_sel),
            .wr_div    (cfg.wr_div),
            .div_init  (DIV_INIT[gi*DIV_W +: DIV_W]),
            .clk_o     (clk_out[gi]),
            .pending_o (pend[gi])
        );
    end

endmodule

// File: doc/clk_gen_multi.md
Name: clk_gen_multi

Overview:
- Parametrised N-channel programmable clock generator, driven from one PLL output clock.
- Each channel produces a registered divided clock (clk_out) with near-50 % duty.
- Divide ratios are runtime-writable; updates are glitch-free and take effect at period boundaries.
- Outputs start only after the PLL lock indication is synchronised, and a sync request phase-aligns all channels; outputs feed the existing ODDR2 forwarding path to IO.

Parameters:
- NUM_CH, 3, number of output channels.
- DIV_W, 8, width of each divide-ratio field.
- DIV_INIT, 24'h0A_05_02, packed reset ratios, NUM_CH*DIV_W bits; channel i uses bits [i*DIV_W +: DIV_W]. Default from 50 MHz gives 25/10/5 MHz.
- CH_W, $clog2(NUM_CH) (minimum 1), channel-select width (derived).

Ports:
- clk  in  1  fabric clock, PLL output.
- rst_n  in  1  reset; asynchronous, active-low.
- locked_in  in  1  PLL LOCKED, asynchronous to clk.
- wr_en  in  1  single-cycle divide-ratio write strobe.
- wr_ch  in  CH_W  target channel of write.
- wr_div  in  DIV_W  new divide ratio.
- sync_req  in  1  single-cycle pulse that restarts all channels in phase.
- clk_out  out  NUM_CH  divided clocks, registered.
- pending  out  NUM_CH  per-channel: written ratio not yet applied.
- running  out  1  synchronised lock; channels active.

Behaviour:
- Reset state (rst_n=0):
  - Sync flops = 0, running = 0, cnt = 0, clk_out = 0, pending = 0.
  - div_cur = div_next = clamp(DIV_INIT field).
- clamp(x) = (x < 2) ? 2 : x. It applies to DIV_INIT fields and to wr_div.
- Lock synchronisation:
  - locked_in goes through a 2-flop synchroniser; the second flop is running.
  - Latency from locked_in rising to running=1 is 2 clk edges.
- Channel counting while running=1:
  - cnt counts 0..div_cur-1, then wraps to 0.
  - hi = (div_cur+1)>>1.
  - clk_out[i] is registered on the same edge as cnt, using the value cnt takes: clk_out = (cnt_next < hi).
  - Period is exactly div_cur cycles, with hi cycles high. Example: div 5 gives 3 high, 2 low.
- Start-up: on the edge after running first reads 1, cnt=0 and clk_out=1. clk_out therefore first goes high 3 edges after locked_in rises.
- While running=0: cnt and clk_out are held at 0. div_cur is retained. Writes are still accepted.
- Write handling:
  - wr_en with wr_ch < NUM_CH sets div_next[wr_ch] = clamp(wr_div) and pending[wr_ch] = 1.
  - wr_ch >= NUM_CH: the write is ignored and nothing changes.
  - A repeat write while pending overwrites div_next; last write wins.
- Apply at boundary:
  - When cnt == div_cur-1 (last cycle of a period) and pending=1: div_cur <= div_next, pending <= 0, cnt <= 0. The new period starts with the new ratio, with no runt pulse.
  - A write coinciding with the boundary applies the written (clamped) value directly at that boundary, and pending ends at 0.
- Apply while stopped: while running=0, pending ratios are applied immediately; pending clears one cycle after the write.
- sync_req while running=1:
  - On the next edge, all channels get cnt=0 and clk_out=1.
  - All pending ratios (including a coincident write) are applied and pending clears.
  - sync_req has priority over normal wrap.
- sync_req while running=0: ignored.
- Lock loss: when locked_in drops, running falls 2 edges later. On the next edge cnt=0 and clk_out=0; the current period is truncated. On re-lock, behaviour follows the start-up rule.
- Reset mid-operation: all state returns to the reset values immediately (asynchronous). Previously written ratios are lost; DIV_INIT is restored.

Decomposition:
- Package clk_gen_pkg:
  - Default DIV_W and NUM_CH constants.
  - The clamp_div function.
  - The hi-count function ((d+1)>>1).
- Sub-module clk_div_ch, generated NUM_CH times:
  - Ports: clk, rst_n, run, sync, wr, wr_div, div_init, clk_o, pending_o.
  - Holds cnt, div_cur, div_next, pending.
- Top level holds the lock synchroniser, write decode and generate loop.

Test Plan:
- Defaults, locked_in raised at cycle 10:
  - running=1 at edge 12; clk_out all 1 at edge 13.
  - ch0 period 2 (1H/1L), ch1 period 5 (3H/2L), ch2 period 10 (5H/5L).
- Write ch0=4 at cnt=0 of a ch0 period:
  - pending[0]=1 for 1 cycle; the old period of 2 completes.
  - Next period is 4 (2H/2L); pending[0]=0 afterwards.
- Write ch1=7, then ch1=9 before the boundary: the applied ratio is 9 (5H/4L).
- Write ch2 coincident with its boundary: the value applies immediately and pending[2] is never observed as 1.
- Edge-case writes:
  - wr_div=0 to ch1 gives period 2.
  - wr_ch=3 with NUM_CH=3 changes nothing; pending stays 000.
- Stagger, sync, lock loss:
  - sync_req mid-period: next edge all clk_out=1, cnt=0, pending cleared.
  - locked_in dropped: clk_out=000 three edges later.
  - Re-lock: restart per the start-up rule with the retained ratios.
